// File: rtl/preemption_controller_pkg.sv
// Shared definitions for the preemption controller slice.
// Holds the FSM state encoding, the trap-cause codes reported on
// trap_cause, and the IO field encodings that the control unit also decodes.
// Optional feature macro used by this slice: PREEMPT_STATS_EN.
package preemption_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_IO_WAIT = 2'd1,
        ST_HALTED  = 2'd2
    } state_e;

    localparam logic [1:0] TRAP_NONE     = 2'b00;
    localparam logic [1:0] TRAP_QUANTUM  = 2'b01;
    localparam logic [1:0] TRAP_FINALIZE = 2'b10;

    localparam logic [1:0] IO_IN  = 2'b10;
    localparam logic [1:0] IO_OUT = 2'b01;

    // Saturating increment for 16-bit event counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/preemption_controller_if.sv
// Bundle between the control unit and the preemption controller.
// Control-unit side (master) drives the decoded system strobes HLT, Finalize,
// PreempON, PreempOFF, IO[1:0] and the user io_ack; the controller (slave)
// returns stall, in_strobe, out_valid, trap, trap_cause[1:0],
// preempt_active and halted.
// With PREEMPT_STATS_EN defined the bundle also carries switch_count[15:0].
interface preemption_controller_if;
    import preemption_controller_pkg::*;

    logic       HLT;
    logic       Finalize;
    logic       PreempON;
    logic       PreempOFF;
    logic [1:0] IO;
    logic       io_ack;

    logic       stall;
    logic       in_strobe;
    logic       out_valid;
    logic       trap;
    logic [1:0] trap_cause;
    logic       preempt_active;
    logic       halted;
`ifdef PREEMPT_STATS_EN
    logic [15:0] switch_count;
`endif

    modport master (
        output HLT, Finalize, PreempON, PreempOFF, IO, io_ack,
        input  stall, in_strobe, out_valid, trap, trap_cause, preempt_active, halted
`ifdef PREEMPT_STATS_EN
        , input switch_count
`endif
    );

    modport slave (
        input  HLT, Finalize, PreempON, PreempOFF, IO, io_ack,
        output stall, in_strobe, out_valid, trap, trap_cause, preempt_active, halted
`ifdef PREEMPT_STATS_EN
        , output switch_count
`endif
    );

endinterface

// File: rtl/preemption_controller_quantum_timer.sv
// Preemption quantum counter.
// Ports: clock, reset (async, active-high), count_en (advance one step),
// clear (return to 0, wins over count_en), expired (counter sits at QUANTUM-1).
// The counter never wraps on its own: it parks at QUANTUM-1 until the owner
// actually takes the quantum trap and clears it, so a deferred expiry is
// not lost.
module quantum_timer
    import preemption_controller_pkg::*;
#(
    parameter int QUANTUM = 64,
    parameter int CNT_W   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(QUANTUM - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign expired = (cnt_q == LAST);

    // Next count: clear beats counting, and counting stops at LAST
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/preemption_controller.sv
// Preemption controller: turns the control unit's system strobes into PC
// stall, IO handshake pulses and OS traps, and owns the quantum timer.
// Ports: clock, reset (async, active-high), bus (preemption_controller_if.slave)
// carrying HLT/Finalize/PreempON/PreempOFF/IO/io_ack in and
// stall/in_strobe/out_valid/trap/trap_cause/preempt_active/halted out.
// Optional macro PREEMPT_STATS_EN adds bus.switch_count, a saturating count
// of quantum traps.
module preemption_controller
    import preemption_controller_pkg::*;
#(
    parameter int QUANTUM = 64,
    parameter int CNT_W   = 8
) (
    input  logic clock,
    input  logic reset,
    preemption_controller_if.slave bus
);

    state_e     state_d, state_q;
    logic       preempt_en_d, preempt_en_q;
    logic       ack_used_d, ack_used_q;
    logic       stall_d, stall_q;
    logic       in_strobe_d, in_strobe_q;
    logic       out_valid_d, out_valid_q;
    logic       trap_d, trap_q;
    logic [1:0] trap_cause_d, trap_cause_q;
    logic       halted_d, halted_q;
`ifdef PREEMPT_STATS_EN
    logic [15:0] switch_count_d, switch_count_q;
`endif

    logic timer_en;
    logic timer_clear;
    logic timer_expired;

    quantum_timer #(
        .QUANTUM (QUANTUM),
        .CNT_W   (CNT_W)
    ) u_quantum_timer (
        .clock    (clock),
        .reset    (reset),
        .count_en (timer_en),
        .clear    (timer_clear),
        .expired  (timer_expired)
    );

    // Next-state and next-output decode. In RUN the events are taken in
    // strict priority; losers are dropped except quantum expiry, which stays
    // pending because the timer parks at QUANTUM-1.
    // ack_used remembers that the current io_ack level already satisfied an
    // IN, so a held io_ack cannot complete a second IN until it drops.
    always_comb begin
        state_d      = state_q;
        preempt_en_d = preempt_en_q;
        ack_used_d   = bus.io_ack ? ack_used_q : 1'b0;
        stall_d      = stall_q;
        in_strobe_d  = 1'b0;
        out_valid_d  = 1'b0;
        trap_d       = 1'b0;
        trap_cause_d = TRAP_NONE;
        halted_d     = halted_q;
        timer_en     = 1'b0;
        timer_clear  = 1'b0;
`ifdef PREEMPT_STATS_EN
        switch_count_d = switch_count_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (bus.HLT) begin
                    state_d  = ST_HALTED;
                    stall_d  = 1'b1;
                    halted_d = 1'b1;
                end else if (bus.Finalize) begin
                    trap_d       = 1'b1;
                    trap_cause_d = TRAP_FINALIZE;
                    timer_clear  = 1'b1;
                end else if (bus.IO == IO_IN) begin
                    state_d = ST_IO_WAIT;
                    stall_d = 1'b1;
                end else if (bus.IO == IO_OUT) begin
                    out_valid_d = 1'b1;
                end else if (preempt_en_q && timer_expired) begin
                    trap_d       = 1'b1;
                    trap_cause_d = TRAP_QUANTUM;
                    timer_clear  = 1'b1;
`ifdef PREEMPT_STATS_EN
                    switch_count_d = sat_inc16(switch_count_q);
`endif
                end
                // The quantum only advances on cycles that keep running user code
                timer_en = preempt_en_q && !stall_d && !trap_d;
                // Every trap hands control to the OS with preemption off
                if (trap_d) begin
                    preempt_en_d = 1'b0;
                end else if (bus.PreempOFF) begin
                    preempt_en_d = 1'b0;
                end else if (bus.PreempON) begin
                    preempt_en_d = 1'b1;
                end
            end
            ST_IO_WAIT: begin
                if (bus.io_ack && !ack_used_q) begin
                    state_d     = ST_RUN;
                    stall_d     = 1'b0;
                    in_strobe_d = 1'b1;
                    ack_used_d  = 1'b1;
                end
            end
            ST_HALTED: begin
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            preempt_en_q <= 1'b0;
            ack_used_q   <= 1'b0;
            stall_q      <= 1'b0;
            in_strobe_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            trap_q       <= 1'b0;
            trap_cause_q <= TRAP_NONE;
            halted_q     <= 1'b0;
`ifdef PREEMPT_STATS_EN
            switch_count_q <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            preempt_en_q <= preempt_en_d;
            ack_used_q   <= ack_used_d;
            stall_q      <= stall_d;
            in_strobe_q  <= in_strobe_d;
            out_valid_q  <= out_valid_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
            halted_q     <= halted_d;
`ifdef PREEMPT_STATS_EN
            switch_count_q <= switch_count_d;
`endif
        end
    end

    assign bus.stall          = stall_q;
    assign bus.in_strobe      = in_strobe_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.trap           = trap_q;
    assign bus.trap_cause     = trap_cause_q;
    assign bus.preempt_active = preempt_en_q;
    assign bus.halted         = halted_q;
`ifdef PREEMPT_STATS_EN
    assign bus.switch_count   = switch_count_q;
`endif

endmodule

// File: tb/tb_preemption_controller.sv
// Bench for preemption_controller with QUANTUM=8. A cycle model written from
// the behavioural rules predicts every output; a negedge process compares
// the DUT with it every cycle, and directed sequences pin literal timings.
// With PREEMPT_STATS_EN defined the switch_count checks are included.
module tb_preemption_controller;
    import preemption_controller_pkg::*;

    localparam int QUANTUM = 8;
    localparam int CNT_W   = 8;
    localparam logic [1:0] IO_NONE = 2'b00;

    logic clock = 1'b0;
    logic reset = 1'b1;
    bit   checkEnable = 1'b0;

    int vectorCount = 0;
    int missCount   = 0;

    preemption_controller_if busIf();

    preemption_controller #(.QUANTUM(QUANTUM), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (busIf)
    );

    // 10-unit clock
    always #5 clock = ~clock;

    // Model state: mode 0=RUN 1=IO_WAIT 2=HALTED
    int mMode;
    int mCnt;
    int mSwitch;
    bit mEn, mAckUsed;
    bit eStall, eIn, eOut, eTrap, eHalted;
    int eCause;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectorCount++;
        if (actual != expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit hlt, input bit fin, input bit on, input bit off,
                                 input logic [1:0] io, input bit ack);
        busIf.HLT       = hlt;
        busIf.Finalize  = fin;
        busIf.PreempON  = on;
        busIf.PreempOFF = off;
        busIf.IO        = io;
        busIf.io_ack    = ack;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input bit ack);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, IO_NONE, ack);
    endtask

    task automatic doReset();
        busIf.HLT = 1'b0; busIf.Finalize = 1'b0; busIf.PreempON = 1'b0;
        busIf.PreempOFF = 1'b0; busIf.IO = IO_NONE; busIf.io_ack = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Behavioural model, advanced on every clock edge or reset assertion
    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                mMode = 0; mCnt = 0; mEn = 0; mAckUsed = 0; mSwitch = 0;
                eStall = 0; eIn = 0; eOut = 0; eTrap = 0; eHalted = 0; eCause = 0;
            end else begin
                automatic bit hlt = busIf.HLT;
                automatic bit fin = busIf.Finalize;
                automatic bit on  = busIf.PreempON;
                automatic bit off = busIf.PreempOFF;
                automatic logic [1:0] io = busIf.IO;
                automatic bit ack = busIf.io_ack;
                automatic bit oldEn = mEn;
                automatic bit quantumDue = mEn && (mCnt == QUANTUM - 1);
                automatic bit trapNow = 0;
                automatic bit leaving = 0;
                eIn = 0; eOut = 0; eTrap = 0; eCause = 0;
                if (mMode == 1) begin
                    if (ack && !mAckUsed) begin
                        mMode = 0; eStall = 0; eIn = 1; mAckUsed = 1;
                    end
                    if (!ack) mAckUsed = 0;
                end else if (mMode == 0) begin
                    if (hlt) begin
                        mMode = 2; eStall = 1; eHalted = 1; leaving = 1;
                    end else if (fin) begin
                        eTrap = 1; eCause = 2; trapNow = 1;
                    end else if (io == 2'b10) begin
                        mMode = 1; eStall = 1; leaving = 1;
                    end else if (io == 2'b01) begin
                        eOut = 1;
                    end else if (quantumDue) begin
                        eTrap = 1; eCause = 1; trapNow = 1;
                        if (mSwitch < 65535) mSwitch++;
                    end
                    if (trapNow) begin
                        mCnt = 0; mEn = 0;
                    end else begin
                        if (oldEn && !leaving && mCnt < QUANTUM - 1) mCnt++;
                        if (off) mEn = 0;
                        else if (on) mEn = 1;
                    end
                    if (!ack) mAckUsed = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (checkEnable) begin
            checkOutput("cmp_stall",          busIf.stall,          eStall);
            checkOutput("cmp_in_strobe",      busIf.in_strobe,      eIn);
            checkOutput("cmp_out_valid",      busIf.out_valid,      eOut);
            checkOutput("cmp_trap",           busIf.trap,           eTrap);
            checkOutput("cmp_trap_cause",     busIf.trap_cause,     eCause);
            checkOutput("cmp_preempt_active", busIf.preempt_active, mEn);
            checkOutput("cmp_halted",         busIf.halted,         eHalted);
`ifdef PREEMPT_STATS_EN
            checkOutput("cmp_switch_count",   busIf.switch_count,   mSwitch);
`endif
        end
    end

    // Hard stop if the stimulus ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int cntStall;
        int cntEvents;
        bit found;

        doReset();
        checkEnable = 1'b1;
        checkOutput("reset_stall",  busIf.stall,  0);
        checkOutput("reset_trap",   busIf.trap,   0);
        checkOutput("reset_halted", busIf.halted, 0);

        // Quantum trap 8 cycles after enable
        applyStimulus(0, 0, 1, 0, IO_NONE, 0);
        checkOutput("t1_active_on", busIf.preempt_active, 1);
        k = 0; found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            idle(0);
            if (busIf.trap) begin k = i; found = 1; end
        end
        checkOutput("t1_trap_delay", k, 8);
        checkOutput("t1_trap_cause", busIf.trap_cause, 1);
        idle(0);
        checkOutput("t1_trap_pulse",  busIf.trap, 0);
        checkOutput("t1_active_off",  busIf.preempt_active, 0);

        // IN with delayed io_ack holds the quantum
        doReset();
        applyStimulus(0, 0, 1, 0, IO_NONE, 0);
        repeat (3) idle(0);
        checkOutput("t2_model_cnt", mCnt, 3);
        cntStall = 0;
        applyStimulus(0, 0, 0, 0, IO_IN, 0);
        if (busIf.stall) cntStall++;
        repeat (4) begin
            idle(0);
            if (busIf.stall) cntStall++;
        end
        idle(1);
        checkOutput("t2_stall_cycles", cntStall, 5);
        checkOutput("t2_in_strobe", busIf.in_strobe, 1);
        checkOutput("t2_stall_released", busIf.stall, 0);
        checkOutput("t2_model_cnt_held", mCnt, 3);
        k = 0; found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            idle(0);
            if (busIf.trap) begin k = i; found = 1; end
        end
        checkOutput("t2_trap_delay", k, 5);
        checkOutput("t2_trap_cause", busIf.trap_cause, 1);

        // Finalize and HLT together: halt wins, inputs ignored afterwards
        doReset();
        applyStimulus(1, 1, 0, 0, IO_NONE, 0);
        checkOutput("t3_halted", busIf.halted, 1);
        checkOutput("t3_stall",  busIf.stall,  1);
        checkOutput("t3_no_trap", busIf.trap, 0);
        cntEvents = 0;
        repeat (3) begin
            applyStimulus(0, 0, 1, 0, IO_IN, 1);
            cntEvents += busIf.in_strobe + busIf.trap + busIf.preempt_active;
        end
        checkOutput("t3_ignored", cntEvents, 0);
        checkOutput("t3_still_halted", busIf.halted, 1);

        // PreempON with PreempOFF: off wins, no trap
        doReset();
        applyStimulus(0, 0, 1, 1, IO_NONE, 0);
        checkOutput("t4_active", busIf.preempt_active, 0);
        cntEvents = 0;
        repeat (2 * QUANTUM) begin
            idle(0);
            cntEvents += busIf.trap;
        end
        checkOutput("t4_no_trap", cntEvents, 0);

        // OUT pulse, then held io_ack across two INs
        doReset();
        applyStimulus(0, 0, 0, 0, IO_OUT, 0);
        checkOutput("t5_out_valid", busIf.out_valid, 1);
        checkOutput("t5_out_nostall", busIf.stall, 0);
        idle(0);
        checkOutput("t5_out_pulse", busIf.out_valid, 0);
        idle(1);
        applyStimulus(0, 0, 0, 0, IO_IN, 1);
        checkOutput("t5_in1_stall", busIf.stall, 1);
        idle(1);
        checkOutput("t5_in1_strobe", busIf.in_strobe, 1);
        applyStimulus(0, 0, 0, 0, IO_IN, 1);
        cntEvents = 0;
        repeat (3) begin
            idle(1);
            cntEvents += busIf.in_strobe;
        end
        checkOutput("t5_in2_blocked", cntEvents, 0);
        checkOutput("t5_in2_stall", busIf.stall, 1);
        idle(0);
        idle(1);
        checkOutput("t5_in2_strobe", busIf.in_strobe, 1);

`ifdef PREEMPT_STATS_EN
        // Three quantum traps and one finalize trap
        doReset();
        repeat (3) begin
            applyStimulus(0, 0, 1, 0, IO_NONE, 0);
            found = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                idle(0);
                if (busIf.trap) found = 1;
            end
        end
        applyStimulus(0, 1, 0, 0, IO_NONE, 0);
        checkOutput("t6_finalize_cause", busIf.trap_cause, 2);
        idle(0);
        checkOutput("t6_switch_count", busIf.switch_count, 3);
`endif

        // Asynchronous reset while waiting for input
        doReset();
        applyStimulus(0, 0, 1, 0, IO_IN, 0);
        checkOutput("t7_wait_stall", busIf.stall, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("t7_rst_stall",  busIf.stall, 0);
        checkOutput("t7_rst_active", busIf.preempt_active, 0);
        checkOutput("t7_rst_trap",   busIf.trap, 0);
        checkOutput("t7_rst_halted", busIf.halted, 0);
`ifdef PREEMPT_STATS_EN
        checkOutput("t7_rst_switch", busIf.switch_count, 0);
`endif
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) idle(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
